// File: rtl/seq_pkg.sv
// Shared definitions for the unlock-code link: state encodings used by the
// transmitter and by the receiver-side bench, plus a counter-width helper.
package seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SEND  = ST_SEND,
        GUARD = ST_GUARD,
        DONE  = ST_DONE
    } seq_state_e;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_tick_div.sv
// Bit-period divider: counts 0..BIT_CYCLES-1 and flags the last clock of each
// bit period. A synchronous clear restarts the period so a new bit (or a new
// state) always gets a full BIT_CYCLES clocks.
module seq_tick_div
    import seq_pkg::*;
#(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = cnt_w(BIT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CW'(BIT_CYCLES - 1));

    // Next count: restart on clear or at the period boundary, else advance.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    // Period counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/code_seq_tx.sv
// Transmit side of the serial unlock-code link. Sends the latched code MSB
// first, BIT_CYCLES clocks per bit, follows each frame with a guard gap, and
// repeats the frame repeat_n+1 times before a one-cycle done pulse.
//
// Handshake: start is only looked at in IDLE; the edge that sees start=1 in
// IDLE accepts the request and latches code/repeat_n. While busy or done are
// high, start and the data ports are ignored. There is no backpressure.
module code_seq_tx
    import seq_pkg::*;
#(
    parameter int CODE_W     = 8,
    parameter int BIT_CYCLES = 4,
    parameter int GUARD_BITS = 2,
    parameter int REPEAT_W   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CODE_W-1:0]   code,
    input  logic [REPEAT_W-1:0] repeat_n,
    output logic                tx_bit,
    output logic                tx_valid,
    output logic                busy,
    output logic                done,
    output logic [1:0]          state
);

    localparam int BW = cnt_w(CODE_W);
    localparam int GW = cnt_w(GUARD_BITS);

    seq_state_e          state_q, state_d;
    logic [CODE_W-1:0]   sh_q, sh_d;
    logic [CODE_W-1:0]   code_lat_q, code_lat_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [GW-1:0]       gcnt_q, gcnt_d;
    logic [REPEAT_W-1:0] frm_q, frm_d;
    logic                tx_bit_q, tx_bit_d;
    logic                tx_valid_q, tx_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                tick;
    logic                div_clr;

    // Every state change (including acceptance) restarts the bit period.
    assign div_clr = (state_d != state_q);

    seq_tick_div #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_tick_div (
        .clk   (clk),
        .rst   (rst),
        .clr_i (div_clr),
        .tick_o(tick)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        code_lat_d = code_lat_q;
        bit_d      = bit_q;
        gcnt_d     = gcnt_q;
        frm_d      = frm_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SEND;
                    sh_d       = code;
                    code_lat_d = code;
                    frm_d      = repeat_n;
                    bit_d      = '0;
                    gcnt_d     = '0;
                end
            end
            SEND: begin
                if (tick) begin
                    if (bit_q == BW'(CODE_W - 1)) begin
                        state_d = GUARD;
                        bit_d   = '0;
                        gcnt_d  = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        sh_d  = {sh_q[CODE_W-2:0], 1'b0};
                    end
                end
            end
            GUARD: begin
                if (tick) begin
                    if (gcnt_q == GW'(GUARD_BITS - 1)) begin
                        gcnt_d = '0;
                        if (frm_q == '0) begin
                            state_d = DONE;
                        end else begin
                            // Repeat frames come from the latched copy, not the live port.
                            frm_d   = frm_q - 1'b1;
                            sh_d    = code_lat_q;
                            bit_d   = '0;
                            state_d = SEND;
                        end
                    end else begin
                        gcnt_d = gcnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with state_q.
        tx_valid_d = (state_d == SEND);
        tx_bit_d   = (state_d == SEND) && sh_d[CODE_W-1];
        busy_d     = (state_d == SEND) || (state_d == GUARD);
        done_d     = (state_d == DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            code_lat_q <= '0;
            bit_q      <= '0;
            gcnt_q     <= '0;
            frm_q      <= '0;
            tx_bit_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            code_lat_q <= code_lat_d;
            bit_q      <= bit_d;
            gcnt_q     <= gcnt_d;
            frm_q      <= frm_d;
            tx_bit_q   <= tx_bit_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_bit   = tx_bit_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign state    = state_q;

endmodule

// File: tb/tb_code_seq_tx.sv
// Bench for code_seq_tx: expected per-cycle waveform is built from the frame
// arithmetic (frame length, bit index by offset) and queued, then compared
// cycle by cycle against the DUT outputs sampled on the falling edge.
module tb_code_seq_tx;
    import seq_pkg::*;

    localparam int CODE_W = 8;
    localparam int BC     = 4;
    localparam int GB     = 2;
    localparam int RW     = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CODE_W-1:0] code;
    logic [RW-1:0]     repeat_n;
    logic              tx_bit, tx_valid, busy, done;
    logic [1:0]        state;
    logic [5:0]        obs;

    int n_cmp = 0;
    int n_err = 0;
    logic [5:0] exp_q[$];

    // Clock and DUT.
    always #5 clk = ~clk;

    code_seq_tx #(
        .CODE_W(CODE_W), .BIT_CYCLES(BC), .GUARD_BITS(GB), .REPEAT_W(RW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .code(code), .repeat_n(repeat_n),
        .tx_bit(tx_bit), .tx_valid(tx_valid), .busy(busy), .done(done), .state(state)
    );

    assign obs = {state, done, busy, tx_valid, tx_bit};

    function automatic logic [5:0] pk(input logic [1:0] st, input logic d, input logic b,
                                      input logic v, input logic t);
        return {st, d, b, v, t};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected waveform from the accepting edge: per cycle, SEND with the bit
    // picked by offset inside the frame, GUARD for the gap, then one DONE cycle.
    task automatic build(input logic [CODE_W-1:0] c, input int rep);
        int frame_len;
        int o;
        frame_len = (CODE_W + GB) * BC;
        for (int k = 0; k < (rep + 1) * frame_len; k++) begin
            o = k % frame_len;
            if (o < CODE_W * BC)
                exp_q.push_back(pk(ST_SEND, 1'b0, 1'b1, 1'b1, c[CODE_W - 1 - o / BC]));
            else
                exp_q.push_back(pk(ST_GUARD, 1'b0, 1'b1, 1'b0, 1'b0));
        end
        exp_q.push_back(pk(ST_DONE, 1'b1, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic idle(input int n, input string tag);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            check(tag, obs, pk(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    // Driver: request one transmission. after_done means the DUT is in its DONE
    // cycle, so start is raised early and must be ignored until IDLE.
    // noise scribbles start/code/repeat_n while busy; abort_at>=0 resets mid-run.
    task automatic send(input logic [CODE_W-1:0] c, input int rep, input bit noise,
                        input bit after_done, input int abort_at);
        logic [5:0] e;
        int k;
        int done_k;
        int n_done;
        code     = c;
        repeat_n = RW'(rep);
        start    = 1'b1;
        if (after_done) begin
            @(posedge clk);
            @(negedge clk);
            check("done_to_idle", obs, pk(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        build(c, rep);
        k = 0;
        done_k = -1;
        n_done = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("wave c=%0h r=%0d k=%0d", c, rep, k), obs, e);
            if (done) begin
                n_done++;
                if (done_k < 0) done_k = k;
            end
            if (noise) begin
                start    = (k == 5) || (k == 20) || ($urandom_range(0, 3) == 0);
                code     = CODE_W'($urandom);
                repeat_n = RW'($urandom);
            end else begin
                start = 1'b0;
            end
            if (k == abort_at) begin
                rst = 1'b1;
                exp_q.delete();
                @(posedge clk);
                @(negedge clk);
                check("abort", obs, pk(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0));
                rst   = 1'b0;
                start = 1'b0;
            end
            k++;
        end
        if (abort_at < 0) begin
            // Edges counted with the accepting edge as the first one.
            check("latency", done_k + 1, (rep + 1) * (CODE_W + GB) * BC + 1);
            check("done_count", n_done, 1);
        end
    endtask

    // Main sequence and final report.
    initial begin
        rst      = 1'b1;
        start    = 1'b1;
        code     = 8'hB4;
        repeat_n = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("reset", obs, pk(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        rst = 1'b0;
        idle(2, "post_reset");

        send(8'hB4, 0, 1'b0, 1'b0, -1);
        idle(2, "gap");
        send(8'h81, 2, 1'b1, 1'b0, -1);
        idle(1, "gap");
        send(8'hC3, 1, 1'b1, 1'b0, -1);
        send(8'h5A, 0, 1'b0, 1'b1, -1);
        idle(2, "gap");

        send(8'hB4, 1, 1'b0, 1'b0, 3 * BC);
        idle(3, "post_abort");
        send(8'hB4, 0, 1'b0, 1'b0, -1);
        idle(1, "gap");
        send(8'h00, 0, 1'b0, 1'b0, -1);
        send(8'hFF, 0, 1'b0, 1'b1, -1);

        for (int i = 0; i < 10; i++) begin
            bit ch;
            ch = 1'($urandom_range(0, 1));
            if (!ch) idle($urandom_range(1, 3), "rand_gap");
            send(CODE_W'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)), ch, -1);
        end
        idle(2, "tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
